// File: rtl/txuart_arbiter_if.sv
// ---------------------------------------------------------------------------
// txuart_arbiter_if
// Bundles the requester side and the transmitter side of the round-robin
// UART transmit arbiter into one interface. Signal names keep the arbiter's
// point of view: i_* are driven into the arbiter, o_* are driven by it.
//
// Signals:
//   i_req_wr    [NREQ]    per-requester write strobe, held until accepted
//   i_req_data  [8*NREQ]  byte k at [8k+7:8k]
//   o_req_busy  [NREQ]    byte k accepted when i_req_wr[k] && !o_req_busy[k]
//   o_grant     [NREQ]    one-hot current grantee, 0 when none
//   o_tx_wr               write strobe to the transmitter
//   o_tx_data   [8]       byte to the transmitter
//   i_tx_busy             busy flag from the transmitter
//
// Modports:
//   slave  - the arbiter itself
//   master - whatever drives the requesters and models the transmitter
// ---------------------------------------------------------------------------
interface txuart_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   i_req_wr;
  logic [8*NREQ-1:0] i_req_data;
  logic [NREQ-1:0]   o_req_busy;
  logic [NREQ-1:0]   o_grant;
  logic              o_tx_wr;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;

  modport slave (
    input  i_req_wr,
    input  i_req_data,
    input  i_tx_busy,
    output o_req_busy,
    output o_grant,
    output o_tx_wr,
    output o_tx_data
  );

  modport master (
    output i_req_wr,
    output i_req_data,
    output i_tx_busy,
    input  o_req_busy,
    input  o_grant,
    input  o_tx_wr,
    input  o_tx_data
  );
endinterface

// File: rtl/txuart_arbiter.sv
// ---------------------------------------------------------------------------
// txuart_arbiter
// Round-robin arbiter sharing one lite UART transmitter among NREQ byte
// sources. Each source uses the transmitter's own wr/busy handshake. The
// arbiter accepts one byte at a time, latches it and presents it to the
// transmitter, then arbitrates the next byte while the current one shifts.
//
// Parameters:
//   NREQ          number of requesters (2..16)
//   LOCK_TIMEOUT  idle cycles before a line lock is released
//
// Ports:
//   i_clk     clock
//   i_reset   synchronous, active-high reset
//   io_bus    txuart_arbiter_if.slave (requester and transmitter signals)
//
// Optional feature (macro TXARB_LINE_LOCK_EN):
//   Once a requester is granted, only that requester is considered until it
//   sends a newline byte (8'h0a) or leaves its strobe low for LOCK_TIMEOUT
//   consecutive idle cycles. Without the macro every byte is arbitrated on
//   its own and no lock state exists.
// ---------------------------------------------------------------------------
module txuart_arbiter #(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic           i_clk,
  input  logic           i_reset,
  txuart_arbiter_if.slave io_bus
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  // Reject configurations outside the supported range at elaboration.
  if (NREQ < 2 || NREQ > 16 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("txuart_arbiter: NREQ must be 2..16 and LOCK_TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ISSUE
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_req_busy;
  logic [NREQ-1:0] r_grant;
  logic            r_tx_wr;
  logic [7:0]      r_tx_data;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_gidx;

  logic [NREQ-1:0] w_cand;
  logic [NREQ-1:0] w_onehot;
  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic [IW:0]     w_pos;
  logic [IW-1:0]   w_next_ptr;

`ifdef TXARB_LINE_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  logic            r_lock;
  logic [IW-1:0]   r_lock_idx;
  logic [CW-1:0]   r_lock_cnt;

  // While a line is locked only the lock owner may compete.
  assign w_cand = r_lock ? (io_bus.i_req_wr & (NREQ'(1) << r_lock_idx))
                         : io_bus.i_req_wr;
`else
  assign w_cand = io_bus.i_req_wr;
`endif

  // Rotating priority search: walk from the rr pointer upward, wrapping at
  // NREQ. Scanning from the far end means the last hit written is the first
  // candidate at or after the pointer.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_pos  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_pos = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_pos >= NREQ_W) begin
        w_pos = w_pos - NREQ_W;
      end
      if (w_cand[w_pos[IW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_pos[IW-1:0];
      end
    end
  end

  assign w_onehot   = NREQ'(1) << w_pick;
  assign w_next_ptr = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;

  // Arbiter state machine. All outputs are registered here so the
  // requesters and the transmitter only ever see flop outputs. IDLE picks a
  // grantee, ACCEPT completes the requester handshake and latches the byte,
  // ISSUE holds the byte on the transmitter until it is taken.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_req_busy <= '1;
      r_grant    <= '0;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= 8'h00;
      r_ptr      <= '0;
      r_gidx     <= '0;
`ifdef TXARB_LINE_LOCK_EN
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_lock_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_grant <= '0;
          if (w_any) begin
            r_gidx     <= w_pick;
            r_grant    <= w_onehot;
            r_req_busy <= ~w_onehot;
            r_state    <= ST_ACCEPT;
`ifdef TXARB_LINE_LOCK_EN
            r_lock     <= 1'b1;
            r_lock_idx <= w_pick;
            r_lock_cnt <= '0;
`endif
          end
`ifdef TXARB_LINE_LOCK_EN
          // No candidate while locked means the owner's strobe is low.
          else if (r_lock) begin
            if (r_lock_cnt == CNT_LAST) begin
              r_lock     <= 1'b0;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 1'b1;
            end
          end
`endif
        end

        ST_ACCEPT: begin
          r_req_busy <= '1;
          if (io_bus.i_req_wr[r_gidx]) begin
            r_tx_data <= io_bus.i_req_data[{r_gidx, 3'b000} +: 8];
            r_ptr     <= w_next_ptr;
            r_tx_wr   <= 1'b1;
            r_state   <= ST_ISSUE;
          end else begin
            // Requester withdrew: abandon the grant, pointer untouched.
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          if (!io_bus.i_tx_busy) begin
            r_tx_wr <= 1'b0;
            r_grant <= '0;
            r_state <= ST_IDLE;
`ifdef TXARB_LINE_LOCK_EN
            if (r_tx_data == 8'h0a) begin
              r_lock <= 1'b0;
            end
`endif
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.o_req_busy = r_req_busy;
  assign io_bus.o_grant    = r_grant;
  assign io_bus.o_tx_wr    = r_tx_wr;
  assign io_bus.o_tx_data  = r_tx_data;

endmodule
